boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 16 +
 rtl/sw_debounce.sv | 50 +++++
 rtl/boot_sequencer.sv | 111 +++++++++++
 tb/tb_boot_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and default parameter values for the boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_DELAY  = 3'd0,
    ST_ARMED  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int unsigned DELAY_DEF      = 1000;
  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam logic [7:0]  TRIG_BYTE_DEF  = 8'h99;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debouncer for a raw push-button; emits the
// accepted level and a one-cycle pulse on its rising edge.
module sw_debounce
  import boot_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q;

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_LAST) lvl_d = sync_q[1];
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= lvl_d & ~lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/boot_sequencer.sv
// Post-reset delay, then launches NCORE cores and tracks them until all halt.
// Optional UART byte trigger enabled by defining BOOT_UART_TRIGGER_EN.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned DELAY      = DELAY_DEF,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NCORE      = 1,
  parameter int unsigned AUTO_START = 1,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [7:0]  TRIG_BYTE  = TRIG_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_c,
  input  logic [NCORE-1:0] halt,
  input  logic [7:0]       uart_recv_data,
  input  logic             uart_recv_valid,
  output logic             uart_recv_ready,
  output logic [NCORE-1:0] start_pulse,
  output logic [NCORE-1:0] running,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCORE-1:0] running_q, running_d;
  logic             rel_q;
  logic             sw_rise;
  logic             deb_level_unused;
  logic             uart_trig;
  logic             trig;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw_i   (sw_c),
    .level_o(deb_level_unused),
    .rise_o (sw_rise)
  );

`ifdef BOOT_UART_TRIGGER_EN
  assign uart_recv_ready = (state_q == ST_ARMED) || (state_q == ST_HALTED);
  assign uart_trig       = uart_recv_ready && uart_recv_valid &&
                           (uart_recv_data == TRIG_BYTE);
`else
  logic uart_unused;
  assign uart_unused     = ^{uart_recv_data, uart_recv_valid};
  assign uart_recv_ready = 1'b0;
  assign uart_trig       = 1'b0;
`endif

  // Both sources are OR-ed, so simultaneous triggers collapse into one launch.
  assign trig = sw_rise | uart_trig;

  // The first edge after reset release only sets rel_q; counting starts on the next,
  // so the launch lands DELAY+1 edges after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_q <= 1'b0;
    else     rel_q <= 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    unique case (state_q)
      ST_DELAY: begin
        if (rel_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (AUTO_START != 0) ? ST_LAUNCH : ST_ARMED;
          end
        end
      end
      ST_ARMED, ST_HALTED: begin
        if (trig) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        running_d = running_q & ~halt;
        if (running_d == '0) state_d = ST_HALTED;
      end
      default: state_d = ST_DELAY;
    endcase
    // Entering LAUNCH sets every core; halts seen during LAUNCH are not applied.
    if (state_d == ST_LAUNCH) running_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DELAY;
      cnt_q     <= '0;
      running_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
    end
  end

  assign start_pulse = {NCORE{state_q == ST_LAUNCH}};
  assign running     = running_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench: an auto-start instance and a trigger-armed instance side by side.
module tb_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sw_a, sw_m;
  logic [1:0] halt_a, halt_m;
  logic [7:0] udat;
  logic       uvld;
  logic       rdy_a, rdy_m;
  logic [1:0] sp_a, sp_m, run_a, run_m;
  logic [2:0] st_a, st_m;

  int n_tests = 0;
  int n_fail  = 0;

  boot_sequencer #(.DELAY(10), .CNT_W(8), .NCORE(2), .AUTO_START(1), .DEB_CYCLES(4),
                   .TRIG_BYTE(8'h99)) dut_a (
    .clk(clk), .rst(rst), .sw_c(sw_a), .halt(halt_a),
    .uart_recv_data(udat), .uart_recv_valid(uvld), .uart_recv_ready(rdy_a),
    .start_pulse(sp_a), .running(run_a), .state_dbg(st_a));

  boot_sequencer #(.DELAY(10), .CNT_W(8), .NCORE(2), .AUTO_START(0), .DEB_CYCLES(4),
                   .TRIG_BYTE(8'h99)) dut_m (
    .clk(clk), .rst(rst), .sw_c(sw_m), .halt(halt_m),
    .uart_recv_data(udat), .uart_recv_valid(uvld), .uart_recv_ready(rdy_m),
    .start_pulse(sp_m), .running(run_m), .state_dbg(st_m));

  // Releases rst at a falling edge and observes the 11 rising edges that follow.
  task automatic count_boot(output int early_a, output int early_m, output logic [1:0] sp11,
                            output logic [1:0] run11, output logic [2:0] sta11,
                            output logic [2:0] stm11);
    early_a = 0; early_m = 0; sp11 = '0; run11 = '0; sta11 = '0; stm11 = '0;
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      if (e < 11) begin
        if (sp_a != 2'b00) early_a++;
        if (sp_m != 2'b00) early_m++;
      end else begin
        sp11 = sp_a; run11 = run_a; sta11 = st_a; stm11 = st_m;
        if (sp_m != 2'b00) early_m++;
      end
    end
  endtask

  // Holds the switch of one instance high for 'hold' cycles, then watches for pulses.
  task automatic press(input bit sel_m, input int hold, output int pulses,
                       output logic [1:0] run_after);
    int cap;
    logic [1:0] sp, rn;
    pulses = 0; run_after = '0; cap = 0;
    for (int i = 0; i < hold + 20; i++) begin
      if (sel_m) sw_m = (i < hold); else sw_a = (i < hold);
      @(negedge clk);
      sp = sel_m ? sp_m : sp_a;
      rn = sel_m ? run_m : run_a;
      if (cap == 1) begin run_after = rn; cap = 2; end
      if (sp != 2'b00) begin
        pulses++;
        if (cap == 0) cap = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sw_a = 0; sw_m = 0; halt_a = '0; halt_m = '0; udat = '0; uvld = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (st_a !== 3'd0 || st_m !== 3'd0) begin n_fail++;
      $display("FAIL reset_state: a=%0d m=%0d want 0", st_a, st_m); end
    n_tests++; if (sp_a !== 2'b00 || sp_m !== 2'b00) begin n_fail++;
      $display("FAIL reset_start_pulse: a=%b m=%b want 00", sp_a, sp_m); end
    n_tests++; if (run_a !== 2'b00 || run_m !== 2'b00) begin n_fail++;
      $display("FAIL reset_running: a=%b m=%b want 00", run_a, run_m); end
    n_tests++; if (rdy_a !== 1'b0 || rdy_m !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: a=%b m=%b want 0", rdy_a, rdy_m); end
  endtask

  task automatic test_auto_start;
    int ea, em;
    logic [1:0] sp11, run11;
    logic [2:0] sta, stm;
    count_boot(ea, em, sp11, run11, sta, stm);
    n_tests++; if (ea != 0) begin n_fail++;
      $display("FAIL auto_early_pulse: got %0d pulses want 0", ea); end
    n_tests++; if (sp11 !== 2'b11) begin n_fail++;
      $display("FAIL auto_pulse_edge11: got %b want 11", sp11); end
    n_tests++; if (sta !== 3'd2 || run11 !== 2'b11) begin n_fail++;
      $display("FAIL auto_launch_state: state=%0d run=%b want 2/11", sta, run11); end
    n_tests++; if (stm !== 3'd1 || em != 0) begin n_fail++;
      $display("FAIL manual_armed: state=%0d pulses=%0d want 1/0", stm, em); end
    @(negedge clk);
    n_tests++; if (sp_a !== 2'b00 || st_a !== 3'd3) begin n_fail++;
      $display("FAIL auto_after_launch: pulse=%b state=%0d want 00/3", sp_a, st_a); end
  endtask

  task automatic test_switch_trigger;
    int p;
    logic [1:0] r;
    press(1'b1, 3, p, r);
    n_tests++; if (p != 0 || st_m !== 3'd1) begin n_fail++;
      $display("FAIL short_press: pulses=%0d state=%0d want 0/1", p, st_m); end
    press(1'b1, 8, p, r);
    n_tests++; if (p != 1 || st_m !== 3'd3 || r !== 2'b11) begin n_fail++;
      $display("FAIL long_press: pulses=%0d state=%0d run=%b want 1/3/11", p, st_m, r); end
    press(1'b1, 8, p, r);
    n_tests++; if (p != 0 || st_m !== 3'd3) begin n_fail++;
      $display("FAIL press_in_run: pulses=%0d state=%0d want 0/3", p, st_m); end
  endtask

  task automatic test_halt;
    int p;
    logic [1:0] r;
    halt_a = 2'b01;
    @(negedge clk);
    n_tests++; if (run_a !== 2'b10 || st_a !== 3'd3) begin n_fail++;
      $display("FAIL halt_core0: run=%b state=%0d want 10/3", run_a, st_a); end
    @(negedge clk);
    n_tests++; if (run_a !== 2'b10 || st_a !== 3'd3) begin n_fail++;
      $display("FAIL halt_repeat: run=%b state=%0d want 10/3", run_a, st_a); end
    halt_a = 2'b10;
    @(negedge clk);
    n_tests++; if (run_a !== 2'b00 || st_a !== 3'd4) begin n_fail++;
      $display("FAIL halt_all: run=%b state=%0d want 00/4", run_a, st_a); end
    halt_a = 2'b11;
    press(1'b0, 8, p, r);
    n_tests++; if (p != 1 || r !== 2'b11) begin n_fail++;
      $display("FAIL relaunch_halt_in_launch: pulses=%0d run=%b want 1/11", p, r); end
    n_tests++; if (st_a !== 3'd4 || run_a !== 2'b00) begin n_fail++;
      $display("FAIL rehalt: state=%0d run=%b want 4/00", st_a, run_a); end
    halt_a = 2'b00;
    press(1'b0, 8, p, r);
    n_tests++; if (p != 1 || st_a !== 3'd3 || run_a !== 2'b11) begin n_fail++;
      $display("FAIL relaunch: pulses=%0d state=%0d run=%b want 1/3/11", p, st_a, run_a); end
  endtask

  task automatic test_reset_midop;
    int ea, em;
    logic [1:0] sp11, run11;
    logic [2:0] sta, stm;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (st_a !== 3'd0 || run_a !== 2'b00 || st_m !== 3'd0 || run_m !== 2'b00)
      begin n_fail++;
      $display("FAIL async_reset_run: a=%0d/%b m=%0d/%b want 0/00", st_a, run_a, st_m, run_m); end
    @(negedge clk);
    count_boot(ea, em, sp11, run11, sta, stm);
    n_tests++; if (ea != 0 || sp11 !== 2'b11 || sta !== 3'd2 || stm !== 3'd1) begin n_fail++;
      $display("FAIL recount_after_run_reset: early=%0d pulse=%b a=%0d m=%0d want 0/11/2/1",
               ea, sp11, sta, stm); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (sp_a !== 2'b00 || st_a !== 3'd0 || run_a !== 2'b00) begin n_fail++;
      $display("FAIL async_reset_launch: pulse=%b state=%0d run=%b want 00/0/00",
               sp_a, st_a, run_a); end
    @(negedge clk);
    count_boot(ea, em, sp11, run11, sta, stm);
    n_tests++; if (ea != 0 || sp11 !== 2'b11 || sta !== 3'd2) begin n_fail++;
      $display("FAIL recount_after_launch_reset: early=%0d pulse=%b state=%0d want 0/11/2",
               ea, sp11, sta); end
    @(negedge clk);
    n_tests++; if (st_a !== 3'd3 || sp_a !== 2'b00 || st_m !== 3'd1) begin n_fail++;
      $display("FAIL post_recount: a=%0d pulse=%b m=%0d want 3/00/1", st_a, sp_a, st_m); end
  endtask

  task automatic test_uart;
    int p;
`ifdef BOOT_UART_TRIGGER_EN
    udat = 8'h55; uvld = 1'b1;
    #1;
    n_tests++; if (rdy_m !== 1'b1 || rdy_a !== 1'b0) begin n_fail++;
      $display("FAIL uart_ready_armed: m=%b a=%b want 1/0", rdy_m, rdy_a); end
    @(negedge clk);
    n_tests++; if (st_m !== 3'd1 || sp_m !== 2'b00) begin n_fail++;
      $display("FAIL uart_wrong_byte: state=%0d pulse=%b want 1/00", st_m, sp_m); end
    udat = 8'h99;
    @(negedge clk);
    n_tests++; if (st_m !== 3'd2 || sp_m !== 2'b11) begin n_fail++;
      $display("FAIL uart_trigger: state=%0d pulse=%b want 2/11", st_m, sp_m); end
    uvld = 1'b0;
    @(negedge clk);
    uvld = 1'b1;
    #1;
    n_tests++; if (rdy_m !== 1'b0 || st_m !== 3'd3) begin n_fail++;
      $display("FAIL uart_ready_run: ready=%b state=%0d want 0/3", rdy_m, st_m); end
    p = 0;
    repeat (4) begin @(negedge clk); if (sp_m != 2'b00) p++; end
    n_tests++; if (p != 0 || st_m !== 3'd3) begin n_fail++;
      $display("FAIL uart_in_run: pulses=%0d state=%0d want 0/3", p, st_m); end
`else
    udat = 8'h99; uvld = 1'b1;
    #1;
    n_tests++; if (rdy_m !== 1'b0 || rdy_a !== 1'b0) begin n_fail++;
      $display("FAIL uart_ready_tied: m=%b a=%b want 0/0", rdy_m, rdy_a); end
    p = 0;
    repeat (4) begin @(negedge clk); if (sp_m != 2'b00) p++; end
    n_tests++; if (p != 0 || st_m !== 3'd1) begin n_fail++;
      $display("FAIL uart_ignored: pulses=%0d state=%0d want 0/1", p, st_m); end
`endif
    uvld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_auto_start();
    test_switch_trigger();
    test_halt();
    test_reset_midop();
    test_uart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
